// File: rtl/exec_pkg.sv
// Shared opcode constants and FSM state encoding for the execute stage.
package exec_pkg;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_LOADI  = 4'b0011;
    localparam logic [3:0] OP_STOREI = 4'b0100;
    localparam logic [3:0] OP_LOAD   = 4'b0101;
    localparam logic [3:0] OP_STORE  = 4'b0110;
    localparam logic [3:0] OP_AND    = 4'b0111;
    localparam logic [3:0] OP_OR     = 4'b1000;
    localparam logic [3:0] OP_MUL    = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/exec_stage_pipe_alu_core.sv
// Combinational ALU for ADD/SUB/AND/OR; carry is the raw carry-out on ADD and the borrow on SUB.
module alu_core
    import exec_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic [3:0]        i_opcode,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_value,
    output logic              o_carry,
    output logic              o_overflow
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_value    = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_value    = w_sum[DATA_W-1:0];
                o_carry    = w_sum[DATA_W];
                o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_SUB: begin
                o_value    = w_diff[DATA_W-1:0];
                o_carry    = w_diff[DATA_W];
                o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_AND:  o_value = i_a & i_b;
            OP_OR:   o_value = i_a | i_b;
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage_pipe.sv
// Single-entry execute stage: one-cycle ALU/move ops plus an iterative shift-add multiplier.
// S_IDLE | accepting ops; S_MUL | multiplier iterating, upstream stalled
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  logic              write_enable,
    input  logic              store_enable,
    input  logic              load_enable,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [MEM_AW-1:0] mem_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [REG_AW-1:0] reg_addr_out,
    output logic [MEM_AW-1:0] mem_addr_out,
    output logic              write_enable_out,
    output logic              store_enable_out,
    output logic              load_enable_out,
    output logic [3:0]        ccr,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int SIDE_W = REG_AW + MEM_AW + 3;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic [SIDE_W-1:0]   r_side_out;
    logic [SIDE_W-1:0]   r_side_pend;
    logic [3:0]          r_ccr;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_is_mul;
    logic                w_out_free;
    logic                w_mul_last;
    logic                w_mul_step;
    logic                w_mul_done;
    logic                w_load;
    logic [3:0]          w_load_op;
    logic [DATA_W-1:0]   w_load_result;
    logic [SIDE_W-1:0]   w_load_side;
    logic [SIDE_W-1:0]   w_side_in;
    logic [DATA_W-1:0]   w_op_result;
    logic [DATA_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]   w_alu_value;
    logic                w_alu_carry;
    logic                w_alu_ovf;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_opcode   (opcode),
        .i_a        (operand1),
        .i_b        (operand2),
        .o_value    (w_alu_value),
        .o_carry    (w_alu_carry),
        .o_overflow (w_alu_ovf)
    );

    assign w_side_in  = {reg_addr, mem_addr, write_enable, store_enable, load_enable};
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == S_IDLE) && !flush && w_out_free;
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (opcode == OP_MUL);

    // The last iteration stalls until the output register is free, so a held result is never overwritten.
    assign w_mul_last = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_mul_step = (r_state == S_MUL) && !flush && (!w_mul_last || w_out_free);
    assign w_mul_done = w_mul_step && w_mul_last;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_op_result = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR:  w_op_result = w_alu_value;
            OP_LOADI, OP_STOREI, OP_STORE: w_op_result = operand1;
            default:                       w_op_result = '0;
        endcase
    end

    assign w_load        = (w_accept && !w_is_mul) || w_mul_done;
    assign w_load_op     = w_mul_done ? OP_MUL : opcode;
    assign w_load_result = w_mul_done ? w_acc_next : w_op_result;
    assign w_load_side   = w_mul_done ? r_side_pend : w_side_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
                S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_side_out  <= '0;
            r_ccr       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_load_result;
            r_side_out  <= w_load_side;
            case (w_load_op)
                OP_ADD, OP_SUB:
                    r_ccr <= {w_load_result[DATA_W-1], w_load_result == '0, w_alu_ovf, w_alu_carry};
                OP_AND, OP_OR, OP_MUL:
                    r_ccr <= {w_load_result[DATA_W-1], w_load_result == '0, 2'b00};
                default: ;
            endcase
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_side_pend <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc       <= '0;
            r_mcand     <= operand1;
            r_mplier    <= operand2;
            r_cnt       <= '0;
            r_side_pend <= w_side_in;
        end else if (w_mul_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid        = r_out_valid;
    assign result           = r_result;
    assign ccr              = r_ccr;
    assign busy             = (r_state == S_MUL);
    assign {reg_addr_out, mem_addr_out, write_enable_out, store_enable_out, load_enable_out} = r_side_out;

endmodule

// File: doc/exec_stage_pipe.md
EXEC_STAGE_PIPE -- requirements
Module: exec_stage_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, operand/result width (>=4).
REQ-002 SHALL provide parameter REG_AW, default 4, register-address width.
REQ-003 SHALL provide parameter MEM_AW, default 4, memory-address width.
REQ-004 SHALL provide ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage accepts operation this cycle.
- opcode  in  4  operation code.
- operand1, operand2  in  DATA_W  source operands.
- write_enable, store_enable, load_enable  in  1  sideband controls.
- reg_addr  in  REG_AW  writeback register.
- mem_addr  in  MEM_AW  memory address.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- result  out  DATA_W  operation result.
- reg_addr_out, mem_addr_out, write_enable_out, store_enable_out, load_enable_out  out  registered sideband copies.
- ccr  out  4  flags {N,Z,V,C}.
- busy  out  1  multiply in progress.

Function
REQ-005 SHALL accept an operation when in_valid && in_ready; in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
REQ-006 SHALL implement opcodes: 0000 NOP, 0001 ADD, 0010 SUB (op1-op2), 0011 LOADI, 0100 STOREI, 0101 LOAD, 0110 STORE, 0111 AND, 1000 OR, 1001 MUL; all others behave as NOP.
REQ-007 SHALL produce result: ADD/SUB/AND/OR = ALU value mod 2^DATA_W; LOADI/STOREI/STORE = operand1; LOAD = 0; NOP = 0; MUL = low DATA_W bits of unsigned op1*op2.
REQ-008 SHALL assert out_valid exactly 1 cycle after acceptance for every non-MUL opcode, NOP included.
REQ-009 SHALL compute MUL by iterative shift-add, one multiplier bit per cycle, out_valid asserted DATA_W+1 cycles after acceptance.
REQ-010 SHALL use states IDLE and MUL: IDLE->MUL on accepted MUL; MUL->IDLE after DATA_W iterations, loading result; flush in MUL -> IDLE, result discarded.
REQ-011 SHALL assert busy only in state MUL.
REQ-012 SHALL hold result, out_valid and all *_out stable while out_valid && !out_ready.
REQ-013 SHALL clear out_valid when out_ready is high and no new result loads that cycle; back-to-back single-cycle ops SHALL sustain one result per cycle with out_ready held high.
REQ-014 SHALL capture sideband inputs at acceptance and present them with the matching result.
REQ-015 SHALL update ccr when the result loads: ADD/SUB set N=msb, Z=(result==0), V=signed overflow, C=carry-out (ADD) / borrow (SUB); AND/OR/MUL set N, Z and clear V, C; other opcodes leave ccr unchanged.
REQ-016 SHALL, on flush, clear out_valid, abort MUL, accept no operation that cycle, and leave ccr unchanged.
REQ-017 SHALL give flush priority over acceptance and over completion of MUL in the same cycle.

Reset
REQ-018 SHALL on rst asynchronously force state=IDLE, out_valid=0, busy=0, result=0, ccr=0, all *_out=0.
REQ-019 SHALL discard any in-progress MUL on reset; first acceptance possible the first clk edge after rst deasserts.

Structure
REQ-020 SHALL place opcode constants and the state encoding in shared package exec_pkg.
REQ-021 SHALL instantiate one combinational sub-module alu_core (parametrised DATA_W, producing value, carry, overflow) for ADD/SUB/AND/OR.
REQ-022 SHALL keep the multiplier datapath (accumulator, shifted multiplicand, bit counter of clog2(DATA_W)+1 bits) inside exec_stage_pipe.

Verification
REQ-023 Reset: assert rst mid-MUL -> busy=0, out_valid=0, ccr=0000, result=0 immediately, without a clock edge.
REQ-024 ADD 0x7FFF+0x0001 (DATA_W=16) -> next cycle result=0x8000, ccr N=1,Z=0,V=1,C=0; SUB 0x0000-0x0001 -> result=0xFFFF, N=1,C=1.
REQ-025 MUL 0x0012*0x0034 -> busy for 16 cycles, in_ready low, result=0x03A8 with out_valid on cycle 17 after acceptance.
REQ-026 Backpressure: out_ready=0 for 3 cycles after STORE op1=0xBEEF -> result, *_out held, in_ready=0; out_ready=1 -> next op accepted same cycle.
REQ-027 Flush during MUL cycle 5 -> busy=0 next cycle, no out_valid, ccr unchanged; following ADD completes normally.
REQ-028 Stream 8 ADDs with out_ready=1 -> 8 consecutive out_valid cycles, sidebands matching each op in order.
